// File: rtl/dmem_if.sv
// Data-memory port bundle between the MEM pipeline stage (master) and the
// multi-cycle data memory responder (slave).
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  stall_o, rdata_o, done_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output stall_o, rdata_o, done_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage of a pipelined
// core. An access is latched from IDLE, the memory stays busy for LATENCY
// cycles, and a single DONE cycle reports the result while the pipeline
// stall is released so MEM/WB can capture rdata_o.
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic   clk_i,
  input  logic   rst_i,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_mis;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_mem [WORDS];

  logic w_access;
  logic w_mem_we;
  logic w_unused_addr;

  // Word accesses only: any nonzero byte offset is an error.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

  // Upper address bits are intentionally dropped so the array aliases.
  assign w_unused_addr = &{1'b0, bus.addr_i[31:DEPTH_LOG2+2]};

  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
  // A reset in the access cycle aborts the write as well as the FSM.
  assign w_mem_we = w_access && r_we && !r_mis && !rst_i;

  assign bus.stall_o = ((r_state == IDLE) && bus.req_i) || (r_state == BUSY);
  assign bus.rdata_o = r_rdata;
  assign bus.done_o  = r_done;
  assign bus.err_o   = r_err;

  // Control FSM: latch request in IDLE, count busy cycles, pulse DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_i) begin
            r_we    <= bus.we_i;
            r_idx   <= bus.addr_i[DEPTH_LOG2+1:2];
            r_mis   <= misaligned(bus.addr_i[1:0]);
            r_wdata <= bus.wdata_i;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= r_mis;
            if (r_mis) begin
              r_rdata <= 32'd0;
            end else if (!r_we) begin
              r_rdata <= r_mem[r_idx];
            end
          end
        end
        // The finished instruction is still in MEM; its req_i is ignored.
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage array: written only at the end of BUSY, never cleared.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning memory busy cycles per access (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the word count (256 words = 1 KiB).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_i, input, 1 bit: MEM-stage access request, held high while the instruction sits in MEM.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port addr_i, input, 32 bits: byte address (the ALU result).
REQ-008 The block SHALL have port wdata_i, input, 32 bits: store data.
REQ-009 The block SHALL have port stall_o, output, 1 bit: freezes the PC, IF/ID, ID/EX and EX/MEM registers and holds the MEM/WB capture while high.
REQ-010 The block SHALL have port rdata_o, output, 32 bits: load data, valid in the DONE cycle for capture by the MEM/WB register.
REQ-011 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err_o, output, 1 bit: misaligned-access flag, valid with done_o.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 IDLE with req_i=1 SHALL latch we_i, addr_i and wdata_i, load the counter with LATENCY-1, and transition to BUSY.
REQ-015 IDLE with req_i=0 SHALL remain in IDLE.
REQ-016 BUSY SHALL decrement the counter each cycle while it is nonzero.
REQ-017 BUSY with counter=0 SHALL perform the access using the latched values and transition to DONE.
REQ-018 DONE SHALL last exactly one cycle and then transition to IDLE unconditionally.
REQ-019 DONE SHALL ignore req_i, because the completed instruction is still present in MEM.
REQ-020 stall_o SHALL be combinational and equal (IDLE and req_i) or BUSY.
REQ-021 A request first seen at cycle T SHALL assert stall_o for cycles T..T+LATENCY and assert done_o at T+LATENCY+1, with stall_o low in that cycle.
REQ-022 The word index SHALL be addr_i[DEPTH_LOG2+1:2].
REQ-023 Upper address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-024 An aligned store SHALL write the full 32-bit wdata into the array at the access point (end of BUSY).
REQ-025 An aligned load SHALL register the array word into rdata_o at the access point.
REQ-026 A misaligned access (addr[1:0]≠0) SHALL suppress any array write, set rdata_o=0, and assert err_o together with done_o.
REQ-027 A store SHALL leave rdata_o unchanged.
REQ-028 rdata_o SHALL hold its value until the next completed load or misaligned access.
REQ-029 done_o and err_o SHALL be registered, high only in the DONE cycle, and 0 otherwise.
REQ-030 Input changes during BUSY SHALL have no effect, because the access uses the latched copies.
REQ-031 Back-to-back requests SHALL be handled as follows: a new request is accepted only from IDLE, so the minimum spacing between done_o pulses is LATENCY+2 cycles.

Reset
REQ-032 With rst_i=1 at a rising edge, the FSM SHALL go to IDLE, the counter to 0, rdata_o to 0, done_o to 0 and err_o to 0.
REQ-033 stall_o SHALL follow REQ-020 during reset, i.e. it depends only on req_i while the FSM is in IDLE.
REQ-034 A reset during BUSY SHALL abort the access: no array write occurs and no done_o pulse is produced.
REQ-035 Array contents SHALL NOT be cleared by reset.
REQ-036 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-037 Bench SHALL check: LATENCY=4; store 0xDEADBEEF to addr 0x10, then load from 0x10 -> stall_o high for 5 cycles, done_o at T+5, rdata_o=0xDEADBEEF in the load's DONE cycle, err_o=0.
REQ-038 Bench SHALL check: load from 0x13 -> err_o=1 and done_o=1 at T+5, rdata_o=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
REQ-039 Bench SHALL check: store 0x12345678 to 0x20, with rst_i=1 pulsed at T+2 -> no done_o, FSM IDLE; a later load of 0x20 returns the prior contents (not 0x12345678).
REQ-040 Bench SHALL check: store to 0x404 with DEPTH_LOG2=8 -> a load from 0x004 returns the same data (wrap-around).
REQ-041 Bench SHALL check: req_i held high continuously across two instructions (addr changes after the DONE cycle) -> exactly two done_o pulses, 6 cycles apart, and the DONE cycle does not start a new access.
REQ-042 Bench SHALL check: LATENCY=1 -> stall_o high for 2 cycles and done_o at T+2.
